// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG scan master: TAP reset, IR/DR scans with TDO capture
module jtag_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 38
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_ir,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic               tap_reset_req,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_TRST,
        S_IDLE,
        S_HDR,
        S_SHIFT,
        S_TAIL,
        S_DONE
    } state_e;

    // Phase counter spans one TCK period: low half first, high half second.
    localparam logic [8:0] HALF = 9'(CLK_DIV);
    localparam logic [8:0] LAST = 9'(2 * CLK_DIV - 1);

    state_e             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [5:0]         step_q, step_d;
    logic               is_ir_q, is_ir_d;
    logic [5:0]         len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_q, rsp_d;

    logic               period_end;
    logic               tck_rise;
    logic [5:0]         hdr_last;
    logic [5:0]         eff_len;

    assign period_end = (cnt_q == LAST);
    assign tck_rise   = (cnt_q == HALF);
    assign hdr_last   = is_ir_q ? 6'd3 : 6'd2;
    assign tck        = (cnt_q >= HALF);
    assign busy       = (state_q != S_IDLE);
    assign rsp_data   = rsp_q;

    // Zero-length requests shift one bit; oversize requests are clipped to the register width.
    always_comb begin
        eff_len = cmd_len;
        if (cmd_len == 6'd0) begin
            eff_len = 6'd1;
        end else if (cmd_len > 6'(MAX_LEN)) begin
            eff_len = 6'(MAX_LEN);
        end
    end

    // State register and scan datapath; reset lands in TRST so the TAP is re-initialised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_TRST;
            cnt_q   <= '0;
            step_q  <= '0;
            is_ir_q <= 1'b0;
            len_q   <= 6'd1;
            data_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            is_ir_q <= is_ir_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
        end
    end

    // Next-state, TMS/TDI sequencing per TCK and TDO capture on the TCK rising cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = period_end ? 9'd0 : cnt_q + 9'd1;
        step_d    = step_q;
        is_ir_d   = is_ir_q;
        len_d     = len_q;
        data_d    = data_q;
        rsp_d     = rsp_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        tms       = 1'b0;
        tdi       = 1'b0;

        case (state_q)
            S_TRST: begin
                tms = (step_q < 6'd5);
                if (period_end) begin
                    if (step_q == 6'd5) begin
                        state_d = S_IDLE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 6'd1;
                    end
                end
            end
            S_IDLE: begin
                cnt_d  = '0;
                step_d = '0;
                if (tap_reset_req) begin
                    state_d = S_TRST;
                end else begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        is_ir_d = cmd_is_ir;
                        len_d   = eff_len;
                        data_d  = cmd_data;
                        rsp_d   = '0;
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                // DR: Select-DR, Capture-DR, Shift-DR; IR adds Select-IR.
                tms = is_ir_q ? (step_q <= 6'd1) : (step_q == 6'd0);
                if (period_end) begin
                    if (step_q == hdr_last) begin
                        state_d = S_SHIFT;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 6'd1;
                    end
                end
            end
            S_SHIFT: begin
                tdi = data_q[step_q];
                tms = (step_q == len_q - 6'd1);
                if (tck_rise) begin
                    rsp_d[step_q] = tdo;
                end
                if (period_end) begin
                    if (step_q == len_q - 6'd1) begin
                        state_d = S_TAIL;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 6'd1;
                    end
                end
            end
            S_TAIL: begin
                // Exit1 -> Update -> Run-Test/Idle.
                tms = (step_q == 6'd0);
                if (period_end) begin
                    if (step_q == 6'd1) begin
                        state_d = S_DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                cnt_d     = '0;
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_TRST;
            end
        endcase
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - directed vector bench for jtag_scan_master
module tb_jtag_scan_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_ir;
    logic [5:0]  cmd_len;
    logic [37:0] cmd_data;
    logic        tap_reset_req;
    logic        rsp_valid;
    logic [37:0] rsp_data;
    logic        tck, tms, tdi, tdo;
    logic        busy;
    logic        tdo_loop, tdo_val;

    int total = 0;
    int bad   = 0;
    int rsp_pulses = 0;
    bit tms_log[$];
    bit tdi_log[$];

    typedef struct {
        logic        is_ir;
        logic [5:0]  len;
        logic [37:0] data;
        logic        loop;
        logic        tval;
        logic [37:0] exp_rsp;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    jtag_scan_master #(.CLK_DIV(2), .MAX_LEN(38)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_is_ir     (cmd_is_ir),
        .cmd_len       (cmd_len),
        .cmd_data      (cmd_data),
        .tap_reset_req (tap_reset_req),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .tck           (tck),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .busy          (busy)
    );

    assign tdo = tdo_loop ? tdi : tdo_val;

    always #5 clk = ~clk;

    always @(posedge tck) begin
        tms_log.push_back(tms);
        tdi_log.push_back(tdi);
    end

    always @(posedge clk) begin
        if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_pins"}, {61'd0, tck, tms, tdi}, 64'b010);
        check({name, "_handshake"}, {61'd0, cmd_ready, rsp_valid, busy}, 64'b001);
        check({name, "_rsp"}, {26'd0, rsp_data}, 64'd0);
    endtask

    // Expected TMS/TDI per TCK: optional 6-TCK TAP reset prefix, then header/shift/tail.
    task automatic check_logs(input string name, input int pre, input bit scan,
                              input logic is_ir, input int len, input logic [37:0] data);
        int h, n, j;
        logic [63:0] at, et, ad, ed;
        h  = is_ir ? 4 : 3;
        n  = pre + (scan ? h + len + 2 : 0);
        at = '0; et = '0; ad = '0; ed = '0;
        for (int i = 0; i < tms_log.size() && i < 64; i++) begin
            at[i] = tms_log[i];
            ad[i] = tdi_log[i];
        end
        for (int i = 0; i < n; i++) begin
            j = i - pre;
            if (i < pre) begin
                et[i] = (i < 5);
            end else if (j < h) begin
                et[i] = is_ir ? (j < 2) : (j == 0);
            end else if (j < h + len) begin
                et[i] = (j == h + len - 1);
                ed[i] = data[j - h];
            end else begin
                et[i] = (j == h + len);
            end
        end
        check({name, "_tck_count"}, 64'(tms_log.size()), 64'(n));
        check({name, "_tms_seq"}, at, et);
        check({name, "_tdi_seq"}, ad, ed);
    endtask

    task automatic wait_ready(output int n);
        n = 1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_scan(input string name, input vec_t v, input bit noise, input bit trst);
        int cyc, pre, len;
        @(negedge clk);
        tms_log.delete();
        tdi_log.delete();
        cmd_is_ir = v.is_ir;
        cmd_len   = v.len;
        cmd_data  = v.data;
        tdo_loop  = v.loop;
        tdo_val   = v.tval;
        cmd_valid = 1'b1;
        pre = 0;
        if (trst) begin
            tap_reset_req = 1'b1;
            pre = 6;
            #1;
            check({name, "_ready_during_trst_req"}, {63'd0, cmd_ready}, 64'd0);
        end
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            @(negedge clk);
            tap_reset_req = 1'b0;
            cyc++;
        end
        check({name, "_accept_wait"}, 64'(cyc), trst ? 64'd25 : 64'd0);
        @(negedge clk);
        cyc = 1;
        check({name, "_busy_after_accept"}, {62'd0, busy, cmd_ready}, 64'b10);
        check({name, "_rsp_cleared"}, {26'd0, rsp_data}, 64'd0);
        if (noise) begin
            cmd_data  = 38'h2A_AAAA_AAAA;
            cmd_is_ir = ~v.is_ir;
            cmd_len   = 6'd5;
        end else begin
            cmd_valid = 1'b0;
        end
        while (!rsp_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 100) cmd_valid = 1'b0;
        end
        check({name, "_latency"}, 64'(cyc), 64'(v.exp_lat));
        check({name, "_rsp_data"}, {26'd0, rsp_data}, {26'd0, v.exp_rsp});
        @(negedge clk);
        check({name, "_pulse_end"}, {62'd0, rsp_valid, busy}, 64'd0);
        len = (v.len == 0) ? 1 : ((v.len > 38) ? 38 : int'(v.len));
        check_logs(name, pre, 1'b1, v.is_ir, len, v.data);
        repeat (4) @(negedge clk);
        check({name, "_rsp_hold"}, {26'd0, rsp_data}, {26'd0, v.exp_rsp});
    endtask

    initial begin
        int n, p0;
        vec_t vt;
        vecs[0] = '{1'b0, 6'd38, 38'h20_0000_0001, 1'b1, 1'b0, 38'h20_0000_0001, 173};
        vecs[1] = '{1'b0, 6'd0,  38'h0,            1'b0, 1'b1, 38'h1,            25};
        vecs[2] = '{1'b0, 6'd50, 38'h0F_0F0F_0F0F, 1'b0, 1'b1, 38'h3F_FFFF_FFFF, 173};
        vecs[3] = '{1'b1, 6'd2,  38'h2,            1'b1, 1'b0, 38'h2,            33};
        vecs[4] = '{1'b0, 6'd8,  38'h3A_5A5A_5AC3, 1'b1, 1'b0, 38'hC3,           53};
        vecs[5] = '{1'b1, 6'd5,  38'h3F_FFFF_FFFF, 1'b0, 1'b0, 38'h0,            45};
        vecs[6] = '{1'b0, 6'd37, 38'h15_5555_5555, 1'b1, 1'b0, 38'h15_5555_5555, 169};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_is_ir = 1'b0; cmd_len = '0; cmd_data = '0;
        tap_reset_req = 1'b0; tdo_loop = 1'b0; tdo_val = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        tms_log.delete();
        tdi_log.delete();
        reset_n = 1'b1;
        wait_ready(n);
        check("trst_ready_cycle", 64'(n), 64'd25);
        check_logs("trst", 6, 1'b0, 1'b0, 0, 38'h0);
        check("idle_pins", {60'd0, busy, tck, tms, tdi}, 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_scan($sformatf("vec%0d", i), vecs[i], (i == 0), 1'b0);
        end

        vt = '{1'b0, 6'd6, 38'h25, 1'b1, 1'b0, 38'h25, 45};
        run_scan("trst_then_cmd", vt, 1'b0, 1'b1);

        @(negedge clk);
        cmd_is_ir = 1'b0; cmd_len = 6'd38; cmd_data = 38'h20_0000_0001;
        tdo_loop = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_busy_in_shift", {63'd0, busy}, 64'd1);
        p0 = rsp_pulses;
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (2) @(negedge clk);
        tms_log.delete();
        tdi_log.delete();
        reset_n = 1'b1;
        wait_ready(n);
        check("abort_trst_ready_cycle", 64'(n), 64'd25);
        check_logs("abort_trst", 6, 1'b0, 1'b0, 0, 38'h0);
        repeat (160) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_pulses), 64'(p0));
        check("abort_rsp_zero", {26'd0, rsp_data}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per TCK half-period; legal range 1..255.
REQ-002 Parameter MAX_LEN, default 38: maximum scan length in bits; sets the width of cmd_data and rsp_data.
REQ-003 Port clk, input, 1: single clock; every register is clocked on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port cmd_valid, input, 1: a scan command is offered.
REQ-006 Port cmd_ready, output, 1: the block accepts the command in this cycle.
REQ-007 Port cmd_is_ir, input, 1: 1 selects an IR scan, 0 selects a DR scan.
REQ-008 Port cmd_len, input, 6: number of bits to shift.
REQ-009 Port cmd_data, input, MAX_LEN: TDI bits, shifted LSB first.
REQ-010 Port tap_reset_req, input, 1: request a TAP reset sequence; sampled only in IDLE.
REQ-011 Port rsp_valid, output, 1: one-cycle pulse marking rsp_data valid.
REQ-012 Port rsp_data, output, MAX_LEN: captured TDO bits; bit i is the i-th bit shifted.
REQ-013 Ports tck, tms, tdi, output, 1 each: JTAG drive toward the target.
REQ-014 Port tdo, input, 1: JTAG return from the target.
REQ-015 Port busy, output, 1: high in every state except IDLE.

Function
REQ-016 Each TCK period SHALL last 2*CLK_DIV clk cycles: tck low for the first CLK_DIV cycles, high for the last CLK_DIV cycles.
REQ-017 tms and tdi SHALL change only in the clk cycle where tck falls, or at the start of a period.
REQ-018 tdo SHALL be sampled in the clk cycle where tck rises.
REQ-019 State machine states: TRST, IDLE, HDR, SHIFT, TAIL, DONE.
REQ-020 TRST: drive 5 TCKs with TMS=1, then 1 TCK with TMS=0; go to IDLE.
REQ-021 IDLE: hold tck=0, tms=0; cmd_ready=1 only in IDLE when tap_reset_req=0.
REQ-022 IDLE with tap_reset_req=1 SHALL go to TRST and take priority over cmd_valid.
REQ-023 A command SHALL be accepted when cmd_valid and cmd_ready are both high; cmd_is_ir, cmd_len and cmd_data are latched in that cycle.
REQ-024 Effective length L SHALL be 1 for cmd_len=0, MAX_LEN for cmd_len>MAX_LEN, and cmd_len otherwise.
REQ-025 HDR, DR scan: TMS sequence 1,0,0, giving 3 TCKs. HDR, IR scan: TMS sequence 1,1,0,0, giving 4 TCKs. tdi=0 throughout HDR.
REQ-026 SHIFT: L TCKs; tdi = latched data bit k on TCK k; TMS=0 except TMS=1 on the final TCK; the tdo sampled on TCK k is stored in rsp_data bit k.
REQ-027 TAIL: TMS sequence 1,0, giving 2 TCKs with tdi=0; the TAP ends in Run-Test/Idle.
REQ-028 DONE: rsp_valid=1 for exactly one clk cycle; rsp_data bits at positions L and above are 0; next state is IDLE.
REQ-029 There is no response backpressure; rsp_data SHALL hold its value until the next accepted command clears it.
REQ-030 Latency from the accept cycle to rsp_valid SHALL be (H+L+2)*2*CLK_DIV+1 clk cycles, with H=3 for DR and H=4 for IR.
REQ-031 cmd_valid while busy SHALL be ignored, with no effect on the scan in progress.

Reset
REQ-032 While reset_n=0: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1.
REQ-033 reset_n assertion mid-scan SHALL abort the scan immediately, with no rsp_valid issued.
REQ-034 After reset_n deasserts, the block SHALL enter TRST automatically; cmd_ready=0 until TRST completes (6 TCKs, 24 clk at CLK_DIV=2).

Verification (CLK_DIV=2)
REQ-035 Release reset -> tms=1 for 5 tck rising edges, then 0 for 1; cmd_ready rises at clk 25.
REQ-036 DR scan, L=38, cmd_data=38'h20_0000_0001, tdo tied to tdi -> rsp_data=38'h20_0000_0001 and rsp_valid exactly 173 clk after accept.
REQ-037 IR scan, L=2, data 2'b10 -> tms per TCK = 1,1,0,0,0,1,1,0; tdi in SHIFT = 0 then 1.
REQ-038 DR scan, cmd_len=0, tdo=1 -> L=1, rsp_data=38'h1; cmd_len=50 -> 38 bits shifted.
REQ-039 reset_n pulsed low during the SHIFT of a DR scan -> no rsp_valid pulse, outputs at reset values, then TRST re-runs.
REQ-040 tap_reset_req and cmd_valid both high in IDLE -> TRST runs first; the command is accepted afterwards, and cmd_data is shifted only after TRST completes.
